rca_pipe: RTL

Parametrised, pipelined ripple-carry adder/subtractor with a valid/ready stream handshake. It is the successor to the fixed 8-bit combinational ripple adders. The WIDTH-bit add is split into WIDTH/CHUNK ripple chunks, and a register stage sits between chunks. The block sustains one operation per cycle at a clock rate set by a CHUNK-bit carry chain rather than a WIDTH-bit one. It sits between an operand producer and a result consumer, either of which may stall.

---
 rtl/rca_pipe.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: WIDTH/CHUNK ripple stages separated by registers,
// with a valid/ready handshake and a bubble-collapsing ready chain.
module rca_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  logic             w_ready   [STAGES+1];
  logic             w_valid_q [STAGES];
  logic             w_vin     [STAGES];
  logic [WIDTH-1:0] w_a_q     [STAGES];
  logic [WIDTH-1:0] w_b_q     [STAGES];
  logic [WIDTH-1:0] w_s_q     [STAGES];
  logic             w_c_q     [STAGES];
  logic             w_ovf_nxt;
  logic             r_ovf;

  assign w_ready[STAGES] = i_out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic [WIDTH-1:0] w_s_in;
    logic             w_c_in;
    logic             w_v_in;
    logic [CHUNK:0]   w_sum;
    logic [WIDTH-1:0] w_s_nxt;
    logic             r_valid;
    logic [WIDTH-1:0] r_s;
    logic             r_c;

    if (k == 0) begin : g_first
      // Subtraction is folded in here: invert B and force the carry in to 1.
      assign w_a_in = i_a;
      assign w_b_in = i_sub ? ~i_b : i_b;
      assign w_c_in = i_sub | i_cin;
      assign w_s_in = '0;
      assign w_v_in = i_in_valid;
    end else begin : g_next
      assign w_a_in = w_a_q[k-1];
      assign w_b_in = w_b_q[k-1];
      assign w_c_in = w_c_q[k-1];
      assign w_s_in = w_s_q[k-1];
      assign w_v_in = w_valid_q[k-1];
    end

    assign w_sum = {1'b0, w_a_in[k*CHUNK +: CHUNK]} + {1'b0, w_b_in[k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, w_c_in};

    always_comb begin
      w_s_nxt = w_s_in;
      w_s_nxt[k*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
    end

    assign w_ready[k] = !r_valid || w_ready[k+1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_valid <= 1'b0;
        r_s     <= '0;
        r_c     <= 1'b0;
      end else if (w_ready[k]) begin
        r_valid <= w_v_in;
        if (w_v_in) begin
          r_s <= w_s_nxt;
          r_c <= w_sum[CHUNK];
        end
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_ready[k] && w_v_in) begin
          r_a <= w_a_in;
          r_b <= w_b_in;
        end
      end

      assign w_a_q[k] = r_a;
      assign w_b_q[k] = r_b;
    end else begin : g_last
      // Carry into the MSB is recovered from the MSB operand bits and the MSB sum bit.
      assign w_ovf_nxt = (w_a_in[WIDTH-1] ^ w_b_in[WIDTH-1] ^ w_sum[CHUNK-1]) ^ w_sum[CHUNK];
      assign w_a_q[k]  = '0;
      assign w_b_q[k]  = '0;
    end

    assign w_valid_q[k] = r_valid;
    assign w_vin[k]     = w_v_in;
    assign w_s_q[k]     = r_s;
    assign w_c_q[k]     = r_c;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_ready[STAGES-1] && w_vin[STAGES-1]) begin
      r_ovf <= w_ovf_nxt;
    end
  end

  assign o_in_ready  = w_ready[0];
  assign o_out_valid = w_valid_q[STAGES-1];
  assign o_s         = w_s_q[STAGES-1];
  assign o_cout      = w_c_q[STAGES-1];
  assign o_ovf       = r_ovf;

endmodule
